parking_lot_controller: RTL and testbench

//  Gate controller for a multi-slot car park. Handles the entrance password FSM,

---
 rtl/parking_lot_controller_pkg.sv | 57 +++++
 rtl/seg7_decoder.sv | 22 ++
 rtl/parking_lot_controller.sv | 196 +++++++++++++++++++
 tb/tb_parking_lot_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_lot_controller_pkg.sv
// ============================================================================
// Module      : parking_lot_controller_pkg
// Description : Shared gate-controller types, segment constants and the
//               digit-to-segment lookup used by the decoder and reset values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_lot_controller_pkg;

  // Gate controller states
  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_PASSWORD = 3'd1,
    ST_WRONG_PASS    = 3'd2,
    ST_RIGHT_PASS    = 3'd3,
    ST_STOP          = 3'd4,
    ST_LOCKOUT       = 3'd5
  } state_t;

  // Active-low gfedcba segment patterns
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;

  // Any digit code above 9 renders as a dash; this one is used on purpose
  localparam logic [3:0] DIGIT_DASH = 4'hF;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module      : seg7_decoder
// Description : 4-bit digit to active-low gfedcba segments; codes >9 show dash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
  import parking_lot_controller_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup; the caller registers the result
  always_comb begin
    seg = seg_encode(digit);
  end

endmodule

`default_nettype wire

// File: rtl/parking_lot_controller.sv
// ============================================================================
// Module      : parking_lot_controller
// Description : Entry-gate controller: password FSM with retry lockout and
//               abandonment timeout, occupancy counter, free-slot display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_lot_controller
  import parking_lot_controller_pkg::*;
#(
  parameter int                    CAPACITY    = 8,
  parameter int                    PW_WIDTH    = 2,
  parameter logic [PW_WIDTH-1:0]   PASS_1      = 2'b01,
  parameter logic [PW_WIDTH-1:0]   PASS_2      = 2'b10,
  parameter int                    WAIT_CYCLES = 16,
  parameter int                    MAX_TRIES   = 3,
  parameter int                    LOCK_CYCLES = 32,
  localparam int                   OCC_W       = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_entrance,
  input  logic                sensor_exit,
  input  logic                car_leave,
  input  logic [PW_WIDTH-1:0] password_1,
  input  logic [PW_WIDTH-1:0] password_2,
  input  logic                pw_valid,
  output logic                GREEN_LED,
  output logic                RED_LED,
  output logic [6:0]          HEX_1,
  output logic [6:0]          HEX_2,
  output logic                lot_full,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_CAP   = OCC_W'(CAPACITY);
  localparam logic [6:0]       FREE_CAP  = 7'(CAPACITY);

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [TRY_W-1:0]   tries, tries_n;
  logic [OCC_W-1:0]   occ_n;
  logic               inc_req;
  logic               green_n, red_n, full_n;
  logic               pw_match;
  logic [TRY_W-1:0]   tries_inc;
  state_t             pw_dest;
  logic [TRY_W-1:0]   pw_tries;
  logic [6:0]         free_n;
  logic [3:0]         tens_n, ones_n;
  logic [6:0]         seg_tens_n, seg_ones_n;

  // Outcome of a password attempt, shared by every state that accepts one
  always_comb begin
    pw_match  = (password_1 == PASS_1) && (password_2 == PASS_2);
    tries_inc = tries + TRY_ONE;
    if (pw_match) begin
      pw_dest  = ST_RIGHT_PASS;
      pw_tries = '0;
    end else begin
      pw_dest  = (tries_inc == TRY_LIMIT) ? ST_LOCKOUT : ST_WRONG_PASS;
      pw_tries = tries_inc;
    end
  end

  // Next-state, timer, retry counter and admission decision
  always_comb begin
    state_n = state;
    timer_n = '0;
    tries_n = tries;
    inc_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sensor_entrance && !lot_full) state_n = ST_WAIT_PASSWORD;
      end
      ST_WAIT_PASSWORD, ST_WRONG_PASS: begin
        timer_n = timer + TMR_ONE;
        if (pw_valid) begin
          state_n = pw_dest;
          tries_n = pw_tries;
          timer_n = '0;
        end else if (timer == WAIT_LAST) begin
          state_n = ST_IDLE;
          tries_n = '0;
          timer_n = '0;
        end
      end
      ST_RIGHT_PASS: begin
        tries_n = '0;
        if (sensor_exit) begin
          inc_req = 1'b1;
          state_n = sensor_entrance ? ST_STOP : ST_IDLE;
        end
      end
      ST_STOP: begin
        // A full lot cannot admit the tailgater, so just wait for it to back off
        if (lot_full) begin
          if (!sensor_entrance) state_n = ST_IDLE;
        end else if (pw_valid) begin
          state_n = pw_dest;
          tries_n = pw_tries;
        end
      end
      ST_LOCKOUT: begin
        timer_n = timer + TMR_ONE;
        if (timer == LOCK_LAST) begin
          state_n = ST_IDLE;
          tries_n = '0;
          timer_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tries_n = '0;
      end
    endcase
  end

  // Occupancy update; a simultaneous entry and departure cancel out
  always_comb begin
    occ_n = occupancy;
    if (inc_req && car_leave && (occupancy != '0)) begin
      occ_n = occupancy;
    end else if (inc_req) begin
      occ_n = (occupancy == OCC_CAP) ? occupancy : occupancy + OCC_ONE;
    end else if (car_leave && (occupancy != '0)) begin
      occ_n = occupancy - OCC_ONE;
    end
    full_n = (occ_n == OCC_CAP);
  end

  // LED patterns and displayed digits for the state being entered
  always_comb begin
    green_n = 1'b0;
    red_n   = 1'b0;
    case (state_n)
      ST_WAIT_PASSWORD, ST_STOP, ST_LOCKOUT: red_n = 1'b1;
      ST_WRONG_PASS:  red_n   = (state == ST_WRONG_PASS) ? ~RED_LED : 1'b1;
      ST_RIGHT_PASS:  green_n = (state == ST_RIGHT_PASS) ? ~GREEN_LED : 1'b1;
      default: begin
        green_n = 1'b0;
        red_n   = 1'b0;
      end
    endcase
    free_n = FREE_CAP - 7'(occ_n);
    if (state_n == ST_LOCKOUT) begin
      tens_n = DIGIT_DASH;
      ones_n = DIGIT_DASH;
    end else begin
      tens_n = 4'(free_n / 7'd10);
      ones_n = 4'(free_n % 7'd10);
    end
  end

  seg7_decoder u_seg_tens (.digit(tens_n), .seg(seg_tens_n));
  seg7_decoder u_seg_ones (.digit(ones_n), .seg(seg_ones_n));

  // All state and outputs registered; reset drops any entry in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      tries     <= '0;
      occupancy <= '0;
      lot_full  <= 1'b0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= seg_encode(4'(CAPACITY / 10));
      HEX_2     <= seg_encode(4'(CAPACITY % 10));
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      tries     <= tries_n;
      occupancy <= occ_n;
      lot_full  <= full_n;
      GREEN_LED <= green_n;
      RED_LED   <= red_n;
      HEX_1     <= seg_tens_n;
      HEX_2     <= seg_ones_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parking_lot_controller.sv
// ============================================================================
// Module      : tb_parking_lot_controller
// Description : Directed scenarios followed by random traffic, each cycle
//               compared against a behavioural model of the gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_lot_controller;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WRONG = 2;
  localparam int M_RIGHT = 3;
  localparam int M_STOP  = 4;
  localparam int M_LOCK  = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance, sensor_exit, car_leave, pw_valid;
  logic [1:0] password_1, password_2;
  logic       GREEN_LED, RED_LED, lot_full;
  logic [6:0] HEX_1, HEX_2;
  logic [3:0] occupancy;

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc       = 0;

  logic [6:0] seg_tab [0:9];

  // Model of the gate: mode, time spent, failed attempts, cars, lamps
  int   m_mode, m_t, m_tries, m_occ;
  logic m_green, m_red;

  always #5 clk = ~clk;

  parking_lot_controller dut (
    .clk(clk), .reset_n(reset_n),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .car_leave(car_leave), .password_1(password_1), .password_2(password_2),
    .pw_valid(pw_valid), .GREEN_LED(GREEN_LED), .RED_LED(RED_LED),
    .HEX_1(HEX_1), .HEX_2(HEX_2), .lot_full(lot_full), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s (cycle %0d): observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex(input bit tens);
    int free;
    if (m_mode == M_LOCK) return 7'b0111111;
    free = 8 - m_occ;
    return tens ? seg_tab[free / 10] : seg_tab[free % 10];
  endfunction

  task automatic model_attempt(input logic [1:0] p1, input logic [1:0] p2);
    if (p1 == 2'b01 && p2 == 2'b10) begin
      m_mode  = M_RIGHT;
      m_tries = 0;
    end else begin
      m_tries++;
      m_t    = 0;
      m_mode = (m_tries >= 3) ? M_LOCK : M_WRONG;
    end
  endtask

  task automatic model_step(input logic en, ex, lv, input logic [1:0] p1, p2, input logic pv);
    int old  = m_mode;
    bit full = (m_occ == 8);
    bit inc  = 0;
    case (m_mode)
      M_IDLE:  if (en && !full) begin m_mode = M_WAIT; m_t = 0; end
      M_WAIT, M_WRONG: begin
        if (pv) model_attempt(p1, p2);
        else if (m_t == 15) begin m_mode = M_IDLE; m_tries = 0; end
        else m_t++;
      end
      M_RIGHT: if (ex) begin inc = 1; m_mode = en ? M_STOP : M_IDLE; end
      M_STOP: begin
        if (full) begin if (!en) m_mode = M_IDLE; end
        else if (pv) model_attempt(p1, p2);
      end
      M_LOCK: begin
        if (m_t == 31) begin m_mode = M_IDLE; m_tries = 0; end
        else m_t++;
      end
      default: m_mode = M_IDLE;
    endcase
    if (inc && lv && m_occ > 0) m_occ = m_occ;
    else if (inc) m_occ = (m_occ < 8) ? m_occ + 1 : 8;
    else if (lv && m_occ > 0) m_occ = m_occ - 1;
    m_green = (m_mode == M_RIGHT) ? ((old == M_RIGHT) ? !m_green : 1'b1) : 1'b0;
    if (m_mode == M_WRONG) m_red = (old == M_WRONG) ? !m_red : 1'b1;
    else m_red = (m_mode == M_WAIT || m_mode == M_STOP || m_mode == M_LOCK);
  endtask

  task automatic compare_all();
    chk("green", GREEN_LED, m_green);
    chk("red", RED_LED, m_red);
    chk("occupancy", occupancy, m_occ);
    chk("lot_full", lot_full, (m_occ == 8));
    chk("hex1", HEX_1, exp_hex(1));
    chk("hex2", HEX_2, exp_hex(0));
  endtask

  // One clock of stimulus, checked after the edge against the model
  task automatic cycle(input logic en, ex, lv, input logic [1:0] p1, p2, input logic pv);
    sensor_entrance = en; sensor_exit = ex; car_leave = lv;
    password_1 = p1; password_2 = p2; pw_valid = pv;
    model_step(en, ex, lv, p1, p2, pv);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    sensor_entrance = 0; sensor_exit = 0; car_leave = 0;
    password_1 = 0; password_2 = 0; pw_valid = 0;
    reset_n = 1'b0;
    #2;
    chk("rst_green", GREEN_LED, 1'b0);
    chk("rst_red", RED_LED, 1'b0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_full", lot_full, 1'b0);
    chk("rst_hex1", HEX_1, 7'b1000000);
    chk("rst_hex2", HEX_2, 7'b0000000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_mode = M_IDLE; m_t = 0; m_tries = 0; m_occ = 0; m_green = 0; m_red = 0;
  endtask

  task automatic enter_car();
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    cycle(0, 1, 0, 2'b00, 2'b00, 0);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    // Reset values
    @(negedge clk);
    do_reset();

    // Good entry
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    chk("wait_red", RED_LED, 1'b1);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    chk("right_green_on", GREEN_LED, 1'b1);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    chk("right_green_toggle", GREEN_LED, 1'b0);
    cycle(0, 1, 0, 2'b00, 2'b00, 0);
    chk("entry_occ", occupancy, 4'd1);
    chk("entry_hex2", HEX_2, 7'b1111000);

    // Lockout after three wrong attempts, then recovery
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b11, 2'b00, 1);
    chk("wrong_red_on", RED_LED, 1'b1);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    chk("wrong_red_toggle", RED_LED, 1'b0);
    cycle(1, 0, 0, 2'b11, 2'b00, 1);
    cycle(1, 0, 0, 2'b11, 2'b00, 1);
    chk("lock_hex1", HEX_1, 7'b0111111);
    chk("lock_hex2", HEX_2, 7'b0111111);
    for (int i = 0; i < 31; i++) cycle(0, 0, 0, 2'b01, 2'b10, (i % 5) == 0);
    chk("lock_still", HEX_2, 7'b0111111);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);
    chk("lock_exit_hex2", HEX_2, 7'b1111000);
    chk("lock_exit_red", RED_LED, 1'b0);
    enter_car();
    chk("after_lock_occ", occupancy, 4'd2);

    // Abandoned entry times out
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 2'b00, 2'b00, 0);
    chk("timeout_not_yet", RED_LED, 1'b1);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);
    chk("timeout_red", RED_LED, 1'b0);
    chk("timeout_occ", occupancy, 4'd2);

    // Fill the lot
    do_reset();
    for (int i = 0; i < 8; i++) enter_car();
    chk("full_flag", lot_full, 1'b1);
    chk("full_hex1", HEX_1, 7'b1000000);
    chk("full_hex2", HEX_2, 7'b1000000);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    chk("full_blocked", RED_LED, 1'b0);
    cycle(0, 0, 1, 2'b00, 2'b00, 0);
    chk("leave_occ", occupancy, 4'd7);
    chk("leave_full", lot_full, 1'b0);
    enter_car();
    chk("refill_occ", occupancy, 4'd8);

    // Tailgating and concurrency
    cycle(0, 0, 1, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    cycle(1, 1, 0, 2'b00, 2'b00, 0);
    chk("stop_occ", occupancy, 4'd8);
    chk("stop_red", RED_LED, 1'b1);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    chk("stop_full_hold", RED_LED, 1'b1);
    cycle(0, 0, 0, 2'b00, 2'b00, 0);
    chk("stop_full_release", RED_LED, 1'b0);
    cycle(0, 0, 1, 2'b00, 2'b00, 0);
    cycle(0, 0, 1, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    cycle(1, 1, 0, 2'b00, 2'b00, 0);
    chk("tailgate_occ", occupancy, 4'd7);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    chk("tailgate_auth", GREEN_LED, 1'b1);
    cycle(0, 1, 1, 2'b00, 2'b00, 0);
    chk("inc_dec_net0", occupancy, 4'd7);
    cycle(1, 0, 0, 2'b00, 2'b00, 0);
    cycle(1, 0, 0, 2'b01, 2'b10, 1);
    cycle(1, 1, 0, 2'b00, 2'b00, 0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic       en, ex, lv, pv;
      logic [1:0] p1, p2;
      en = ($urandom % 3) == 0;
      ex = ($urandom % 3) == 0;
      lv = ($urandom % 12) == 0;
      pv = ($urandom % 4) == 0;
      if (($urandom % 2) == 0) begin
        p1 = 2'b01; p2 = 2'b10;
      end else begin
        p1 = 2'($urandom); p2 = 2'($urandom);
      end
      cycle(en, ex, lv, p1, p2, pv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
